// File: rtl/datapath_if.sv
// Control and data bundle between the control unit and the datapath.
// The control unit drives selects and load data; flags and ALU result return.
interface datapath_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       resReg;
    logic [1:0]       wen;
    logic             wsel;
    logic [1:0]       asel;
    logic [1:0]       bsel;
    logic             datasel;
    logic [1:0]       alusel;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] aluOut;
    logic             eq;
    logic             zero;

    modport master (
        output resReg, wen, wsel, asel, bsel,
        output datasel, alusel, dataIn,
        input  aluOut, eq, zero
    );

    modport slave (
        input  resReg, wen, wsel, asel, bsel,
        input  datasel, alusel, dataIn,
        output aluOut, eq, zero
    );
endinterface

// File: rtl/datapath.sv
// Three-register datapath with a four-op ALU and registered eq/zero flags.
// Operands read live register state; writes and flags land on the next edge.
module datapath #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       resDatapath,
    datapath_if.slave  bus
);
    logic [WIDTH-1:0] r [3];
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wdata;
    logic [2:0]       we;
    logic             eq_q;
    logic             zero_q;

    always_comb begin
        a = '0;
        unique case (bus.asel)
            2'b00:   a = r[0];
            2'b01:   a = r[1];
            2'b10:   a = r[2];
            default: a = '0;
        endcase
    end

    always_comb begin
        b = '0;
        unique case (bus.bsel)
            2'b00:   b = r[0];
            2'b01:   b = r[1];
            2'b10:   b = r[2];
            default: b = '0;
        endcase
    end

    always_comb begin
        alu = '0;
        unique case (bus.alusel)
            2'b00:   alu = a + b;
            2'b01:   alu = a - b;
            2'b10:   alu = a & b;
            default: alu = a ^ b;
        endcase
    end

    always_comb begin
        we = 3'b000;
        unique case (bus.wen)
            2'b01:   we = 3'b001;
            2'b10:   we = 3'b010;
            2'b11:   we = 3'b100;
            default: we = 3'b000;
        endcase
    end

    assign wdata = bus.datasel ? bus.dataIn : alu;

    // Per-register clear wins over a write to the same register.
    always_ff @(posedge clk) begin
        if (!resDatapath) begin
            for (int i = 0; i < 3; i++) r[i] <= '0;
            eq_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.resReg[i])
                    r[i] <= '0;
                else if (we[i])
                    r[i] <= wdata;
            end
            if (bus.wsel) begin
                eq_q   <= (a == b);
                zero_q <= (alu == '0);
            end
        end
    end

    assign bus.aluOut = alu;
    assign bus.eq     = eq_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_datapath.sv
// Randomized and directed bench for datapath against an arithmetic model.
// Register contents are observed through aluOut as Rx+0.
module tb_datapath;
    localparam int W = 8;

    logic clk;
    logic resDatapath;
    int   n_tests;
    int   n_fail;

    logic [W-1:0] mr [3];
    logic         meq;
    logic         mz;

    datapath_if #(.WIDTH(W)) bus ();

    datapath #(.WIDTH(W)) dut (
        .clk         (clk),
        .resDatapath (resDatapath),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_opnd(input logic [1:0] s);
        if (s == 2'b11) return '0;
        return mr[s];
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [1:0] op);
        int xi;
        int yi;
        int m;
        xi = int'(x);
        yi = int'(y);
        m  = 1 << W;
        case (op)
            2'd0:    return W'((xi + yi) % m);
            2'd1:    return W'((xi - yi + m) % m);
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    // One clock: apply controls, check ALU, advance model, check flags.
    task automatic drive(input logic rst, input logic [2:0] rr,
                         input logic [1:0] w, input logic ws,
                         input logic [1:0] as, input logic [1:0] bs,
                         input logic ds, input logic [1:0] op,
                         input logic [W-1:0] d);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        resDatapath    = rst;
        bus.resReg     = rr;
        bus.wen        = w;
        bus.wsel       = ws;
        bus.asel       = as;
        bus.bsel       = bs;
        bus.datasel    = ds;
        bus.alusel     = op;
        bus.dataIn     = d;
        #1;
        x   = m_opnd(as);
        y   = m_opnd(bs);
        res = m_alu(x, y, op);
        chk("alu", 32'(bus.aluOut), 32'(res));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) mr[i] = '0;
            meq = 1'b0;
            mz  = 1'b0;
        end else begin
            if (ws) begin
                meq = (x == y);
                mz  = (res == '0);
            end
            for (int i = 0; i < 3; i++) begin
                if (!rr[i])
                    mr[i] = '0;
                else if (int'(w) == i + 1)
                    mr[i] = ds ? d : res;
            end
        end
        #1;
        chk("eq", 32'(bus.eq), 32'(meq));
        chk("zero", 32'(bus.zero), 32'(mz));
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [W-1:0] v);
        drive(1'b1, 3'b111, 2'(idx + 1), 1'b0,
              2'b11, 2'b11, 1'b1, 2'b00, v);
    endtask

    task automatic peek(input string tag, input logic [1:0] as,
                        input logic [1:0] bs, input logic [1:0] op,
                        input logic [W-1:0] exp);
        resDatapath = 1'b1;
        bus.resReg  = 3'b111;
        bus.wen     = 2'b00;
        bus.wsel    = 1'b0;
        bus.asel    = as;
        bus.bsel    = bs;
        bus.alusel  = op;
        #1;
        chk(tag, 32'(bus.aluOut), 32'(exp));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 3; i++) mr[i] = '0;
        meq = 1'b0;
        mz  = 1'b0;
        resDatapath = 1'b0;
        bus.resReg  = 3'b111;
        bus.wen     = 2'b00;
        bus.wsel    = 1'b0;
        bus.asel    = 2'b11;
        bus.bsel    = 2'b11;
        bus.datasel = 1'b0;
        bus.alusel  = 2'b00;
        bus.dataIn  = '0;
        @(negedge clk);

        drive(1'b0, 3'b111, 2'b00, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 8'h00);
        peek("rst_r0", 2'b00, 2'b11, 2'b00, 8'h00);
        peek("rst_r1", 2'b01, 2'b11, 2'b00, 8'h00);
        peek("rst_r2", 2'b10, 2'b11, 2'b00, 8'h00);
        chk("rst_eq", 32'(bus.eq), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        for (int k = 0; k < 4; k++)
            peek("rst_alu", 2'b00, 2'b01, 2'(k), 8'h00);

        load(0, 8'd5);
        load(1, 8'd3);
        drive(1'b1, 3'b111, 2'b11, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 8'h00);
        peek("add_r2", 2'b10, 2'b11, 2'b00, 8'd8);

        load(0, 8'h02);
        load(1, 8'h05);
        peek("wrap", 2'b00, 2'b01, 2'b01, 8'hFD);
        drive(1'b1, 3'b111, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'b01, 8'h00);
        chk("wrap_eq", 32'(bus.eq), 32'd0);
        chk("wrap_zero", 32'(bus.zero), 32'd0);

        load(0, 8'h2A);
        load(1, 8'h2A);
        drive(1'b1, 3'b111, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'b01, 8'h00);
        chk("equ_eq", 32'(bus.eq), 32'd1);
        chk("equ_zero", 32'(bus.zero), 32'd1);
        load(1, 8'h10);
        drive(1'b1, 3'b111, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 8'h00);
        chk("equ_hold", 32'(bus.eq), 32'd1);

        load(0, 8'h11);
        load(2, 8'h33);
        drive(1'b1, 3'b101, 2'b10, 1'b0, 2'b11, 2'b11, 1'b1, 2'b00, 8'h77);
        peek("clr_r1", 2'b01, 2'b11, 2'b00, 8'h00);
        peek("clr_r0", 2'b00, 2'b11, 2'b00, 8'h11);
        peek("clr_r2", 2'b10, 2'b11, 2'b00, 8'h33);

        load(1, 8'h22);
        drive(1'b1, 3'b111, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 8'h00);
        chk("mid_eq1", 32'(bus.eq), 32'd1);
        drive(1'b0, 3'b111, 2'b01, 1'b1, 2'b00, 2'b01, 1'b1, 2'b00, 8'h55);
        peek("mid_r0", 2'b00, 2'b11, 2'b00, 8'h00);
        peek("mid_r1", 2'b01, 2'b11, 2'b00, 8'h00);
        peek("mid_r2", 2'b10, 2'b11, 2'b00, 8'h00);
        chk("mid_eq", 32'(bus.eq), 32'd0);
        chk("mid_zero", 32'(bus.zero), 32'd0);

        load(0, 8'd4);
        drive(1'b1, 3'b111, 2'b01, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 8'd9);
        chk("rw_eq", 32'(bus.eq), 32'd1);
        peek("rw_r0", 2'b00, 2'b11, 2'b00, 8'd9);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] rr;
            rr[0] = ($urandom_range(0, 7) != 0);
            rr[1] = ($urandom_range(0, 7) != 0);
            rr[2] = ($urandom_range(0, 7) != 0);
            drive(($urandom_range(0, 29) != 0), rr,
                  2'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom),
                  1'($urandom), 2'($urandom), W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
